// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: pc feedback, imem request/response and decode queue.
// The master modport is the fetch unit; slave is its environment.
interface ifetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_enable;
  logic               flush;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               imem_resp_err;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_fault;
  logic               id_ready;

  modport master (
    input  pc_addr, flush,
    output pc_enable,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  imem_resp_err,
    output id_valid, id_instr, id_pc, id_fault,
    input  id_ready
  );

  modport slave (
    output pc_addr, flush,
    input  pc_enable,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output imem_resp_err,
    input  id_valid, id_instr, id_pc, id_fault,
    output id_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding imem read, queued into a
// small registered FIFO toward decode, with flush/redirect handling.
module ifetch_unit #(
  parameter int ADDR_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  ifetch_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DROP, HALT
  } state_t;

  typedef struct packed {
    logic               fault;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t state, state_n;

  entry_t mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] req_pc;

  logic   req_valid;
  logic   fire;
  logic   push;
  logic   pop;
  logic   space;
  logic   aligned;
  entry_t push_e;
  entry_t head;

  assign space   = count < CW'(FIFO_DEPTH);
  assign aligned = bus.pc_addr[1:0] == 2'b00;
  assign fire    = req_valid && bus.imem_req_ready;
  assign pop     = bus.id_valid && bus.id_ready;
  assign head    = mem[rd_ptr];

  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    push      = 1'b0;
    push_e    = '0;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (space && aligned) begin
          req_valid = 1'b1;
          if (bus.imem_req_ready) state_n = WAIT;
        end else if (space) begin
          push         = 1'b1;
          push_e.fault = 1'b1;
          push_e.pc    = bus.pc_addr;
          state_n      = HALT;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          push         = 1'b1;
          push_e.fault = bus.imem_resp_err;
          push_e.pc    = req_pc;
          push_e.instr = bus.imem_resp_data;
          state_n      = bus.imem_resp_err ? HALT : REQ;
        end
      end
      DROP: if (bus.imem_resp_valid) state_n = REQ;
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
    // A response landing with the flush is the in-flight one; no need to drop later
    if (bus.flush) begin
      req_valid = 1'b0;
      push      = 1'b0;
      if ((state == WAIT || state == DROP)
          && !bus.imem_resp_valid)
        state_n = DROP;
      else
        state_n = REQ;
    end
    if (reset) begin
      req_valid = 1'b0;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_n;
      if (fire) req_pc <= bus.pc_addr;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_e;
  end

  assign bus.pc_enable      = fire;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_valid ? bus.pc_addr : '0;
  assign bus.id_valid       = count != '0;
  assign bus.id_instr = bus.id_valid ? head.instr : '0;
  assign bus.id_pc    = bus.id_valid ? head.pc    : '0;
  assign bus.id_fault = bus.id_valid && head.fault;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: pc block and imem modelled per cycle,
// decode pops collected and compared to hand-computed values.
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic reset;

  ifetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  ifetch_unit #(
    .ADDR_W(64), .INSTR_W(32), .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        f;
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        got[$];
  int          fires;
  int          n_en;
  int          nchk;
  int          nfail;
  bit          auto_mem;
  bit          pend;
  logic [63:0] pend_addr;
  logic        obs_valid, obs_en, obs_idv, obs_fault;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    logic f;
    if (auto_mem) begin
      bus.imem_resp_valid = pend;
      bus.imem_resp_data  = pend ? (pend_addr[31:0] ^ 32'hA5A5A5A5) : '0;
      bus.imem_resp_err   = 1'b0;
    end
    #1;
    obs_valid = bus.imem_req_valid;
    obs_addr  = bus.imem_req_addr;
    obs_en    = bus.pc_enable;
    obs_idv   = bus.id_valid;
    obs_pc    = bus.id_pc;
    obs_instr = bus.id_instr;
    obs_fault = bus.id_fault;
    f = obs_valid && bus.imem_req_ready;
    if (f) fires++;
    if (obs_en) n_en++;
    if (obs_idv && bus.id_ready)
      got.push_back('{obs_fault, obs_pc, obs_instr});
    @(posedge clk);
    #1;
    if (obs_en) bus.pc_addr = bus.pc_addr + 64'd4;
    pend      = f;
    pend_addr = obs_addr;
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    bus.pc_addr         = '0;
    bus.flush           = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    bus.id_ready        = 1'b1;
    auto_mem            = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    pend  = 1'b0;
    got.delete();
    fires = 0;
    n_en  = 0;
    check("rst_idv", 64'(bus.id_valid), 0);
    check("rst_reqv", 64'(bus.imem_req_valid), 0);
    check("rst_en", 64'(bus.pc_enable), 0);
    check("rst_idpc", bus.id_pc, 0);
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    pend  = 1'b0;
    pend_addr = '0;
    fires = 0;
    n_en  = 0;

    // 1: sequential fetch
    do_reset();
    cyc();
    check("t1_bubble", 64'(obs_valid), 0);
    repeat (15) cyc();
    check("t1_fires", 64'(fires), 8);
    check("t1_en", 64'(n_en), 8);
    check("t1_size", 64'(got.size()), 7);
    foreach (got[i]) begin
      check("t1_pc", got[i].pc, 64'(4 * i));
      check("t1_ins", 64'(got[i].ins),
            64'(32'(4 * i) ^ 32'hA5A5A5A5));
    end

    // 2: backpressure
    do_reset();
    bus.id_ready = 1'b0;
    repeat (20) cyc();
    check("t2_fires", 64'(fires), 4);
    check("t2_en", 64'(n_en), 4);
    check("t2_reqv", 64'(obs_valid), 0);
    check("t2_idv", 64'(obs_idv), 1);
    check("t2_nopop", 64'(got.size()), 0);
    bus.id_ready = 1'b1;
    repeat (14) cyc();
    check("t2_drain", 64'(got.size() >= 4), 1);
    foreach (got[i]) begin
      check("t2_pc", got[i].pc, 64'(4 * i));
      check("t2_ins", 64'(got[i].ins),
            64'(32'(4 * i) ^ 32'hA5A5A5A5));
    end

    // 3: request stall
    do_reset();
    bus.imem_req_ready = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t3_v", 64'(obs_valid), 1);
      check("t3_a", obs_addr, 0);
      check("t3_en", 64'(obs_en), 0);
    end
    bus.imem_req_ready = 1'b1;
    cyc();
    check("t3_fire_en", 64'(obs_en), 1);
    check("t3_fire_a", obs_addr, 0);
    cyc();
    cyc();
    check("t3_next_a", obs_addr, 64'h4);

    // 4: flush in WAIT, late response
    do_reset();
    auto_mem = 1'b0;
    cyc();
    cyc();
    check("t4_fire", 64'(obs_en), 1);
    bus.flush   = 1'b1;
    bus.pc_addr = 64'h20;
    cyc();
    check("t4_fl_v", 64'(obs_valid), 0);
    check("t4_fl_en", 64'(obs_en), 0);
    bus.flush = 1'b0;
    cyc();
    check("t4_drop_v", 64'(obs_valid), 0);
    cyc();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h00000BAD;
    cyc();
    bus.imem_resp_valid = 1'b0;
    cyc();
    check("t4_redir_v", 64'(obs_valid), 1);
    check("t4_redir_a", obs_addr, 64'h20);
    check("t4_idv", 64'(obs_idv), 0);
    auto_mem = 1'b1;
    repeat (4) cyc();
    check("t4_size", 64'(got.size()), 2);
    if (got.size() >= 2) begin
      check("t4_pc0", got[0].pc, 64'h20);
      check("t4_ins0", 64'(got[0].ins), 64'hA5A5A585);
      check("t4_pc1", got[1].pc, 64'h24);
    end

    // 5: flush with response in same cycle
    do_reset();
    auto_mem = 1'b0;
    cyc();
    cyc();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h00001234;
    bus.flush           = 1'b1;
    bus.pc_addr         = 64'h40;
    cyc();
    check("t5_fl_en", 64'(obs_en), 0);
    check("t5_fl_v", 64'(obs_valid), 0);
    bus.imem_resp_valid = 1'b0;
    bus.flush           = 1'b0;
    cyc();
    check("t5_idv", 64'(obs_idv), 0);
    check("t5_v", 64'(obs_valid), 1);
    check("t5_a", obs_addr, 64'h40);
    cyc();
    check("t5_idv2", 64'(obs_idv), 0);

    // 6: misaligned fault, flush resume, reset mid-WAIT
    do_reset();
    bus.id_ready = 1'b0;
    bus.pc_addr  = 64'hDEADBEEF;
    cyc();
    cyc();
    check("t6_v", 64'(obs_valid), 0);
    check("t6_en", 64'(obs_en), 0);
    cyc();
    check("t6_idv", 64'(obs_idv), 1);
    check("t6_fault", 64'(obs_fault), 1);
    check("t6_pc", obs_pc, 64'hDEADBEEF);
    check("t6_ins", 64'(obs_instr), 0);
    repeat (3) cyc();
    check("t6_halt_v", 64'(obs_valid), 0);
    check("t6_fires", 64'(fires), 0);
    bus.flush   = 1'b1;
    bus.pc_addr = 64'h100;
    cyc();
    bus.flush = 1'b0;
    cyc();
    check("t6_res_idv", 64'(obs_idv), 0);
    check("t6_res_v", 64'(obs_valid), 1);
    check("t6_res_a", obs_addr, 64'h100);
    reset       = 1'b1;
    auto_mem    = 1'b0;
    bus.pc_addr = '0;
    cyc();
    check("t6_rst_en", 64'(obs_en), 0);
    reset               = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h00000BAD;
    cyc();
    bus.imem_resp_valid = 1'b0;
    bus.id_ready        = 1'b1;
    cyc();
    check("t6_late_idv", 64'(obs_idv), 0);
    cyc();
    check("t6_late_idv2", 64'(obs_idv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
